// File: rtl/alu_cmd_sched.sv
// Command scheduler: queues parsed commands, launches the shift-add multiplier
// for supported ones, and returns products or error codes in command order.
module alu_cmd_sched #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_dtype,
  input  logic [4:0]  cmd_op,
  input  logic [15:0] cmd_src1,
  input  logic [15:0] cmd_src2,
  output logic        mul_start,
  output logic [3:0]  mul_dtype,
  output logic [4:0]  mul_op,
  output logic [15:0] mul_src1,
  output logic [15:0] mul_src2,
  input  logic        mul_done,
  input  logic [31:0] mul_res,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_err,
  output logic        busy
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [3:0]  SUP_DTYPE = 4'h2;
  localparam logic [4:0]  SUP_OP    = 5'h03;
  localparam logic [31:0] TIMEOUT_CODE = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [3:0]  dtype;
    logic [4:0]  op;
    logic [15:0] src1;
    logic [15:0] src2;
  } cmd_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HOLD
  } state_t;

  cmd_t          mem [DEPTH];
  cmd_t          cmd_in;
  cmd_t          head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_d;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_d;
  state_t        state;
  state_t        state_d;
  logic          push;
  logic          pop;
  logic          supported;
  logic [31:0]   res_data_d;
  logic          res_err_d;

  assign cmd_in    = {cmd_dtype, cmd_op, cmd_src1, cmd_src2};
  assign head      = mem[rd_ptr];
  assign push      = cmd_valid && cmd_ready;
  assign supported = (head.dtype == SUP_DTYPE) && (head.op == SUP_OP);

  // Command storage; reset only clears the pointers, stale entries are unreachable
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= cmd_in;
    end
  end

  // Occupancy after this cycle's push/pop
  always_comb begin
    count_d = count;
    if (push && !pop) begin
      count_d = count + CW'(1);
    end else if (pop && !push) begin
      count_d = count - CW'(1);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next state, pop strobe, timer and result selection
  always_comb begin
    state_d    = state;
    pop        = 1'b0;
    timer_d    = timer;
    res_data_d = res_data;
    res_err_d  = res_err;
    case (state)
      S_IDLE: begin
        if (count != '0) begin
          pop = 1'b1;
          if (supported) begin
            state_d = S_ISSUE;
          end else begin
            res_data_d = '0;
            res_err_d  = 1'b1;
            state_d    = S_HOLD;
          end
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A completion on the last allowed cycle still counts as success
        if (mul_done) begin
          res_data_d = mul_res;
          res_err_d  = 1'b0;
          state_d    = S_HOLD;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          res_data_d = TIMEOUT_CODE;
          res_err_d  = 1'b1;
          state_d    = S_HOLD;
        end else begin
          timer_d = timer + TW'(1);
        end
      end
      S_HOLD: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pointers, counters and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      timer     <= '0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      mul_start <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_err   <= 1'b0;
      mul_dtype <= '0;
      mul_op    <= '0;
      mul_src1  <= '0;
      mul_src2  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + AW'(1);
        mul_dtype <= head.dtype;
        mul_op    <= head.op;
        mul_src1  <= head.src1;
        mul_src2  <= head.src2;
      end
      count     <= count_d;
      timer     <= timer_d;
      cmd_ready <= (count_d != CW'(DEPTH));
      busy      <= (state_d != S_IDLE) || (count_d != '0);
      mul_start <= (state_d == S_ISSUE);
      res_valid <= (state_d == S_HOLD);
      res_data  <= res_data_d;
      res_err   <= res_err_d;
    end
  end

endmodule

// File: tb/tb_alu_cmd_sched.sv
// Self-checking bench for alu_cmd_sched with a latency-programmable multiplier model.
module tb_alu_cmd_sched;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 64;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_dtype;
  logic [4:0]  cmd_op;
  logic [15:0] cmd_src1;
  logic [15:0] cmd_src2;
  logic        mul_start;
  logic [3:0]  mul_dtype;
  logic [4:0]  mul_op;
  logic [15:0] mul_src1;
  logic [15:0] mul_src2;
  logic        mul_done;
  logic [31:0] mul_res;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_err;
  logic        busy;

  alu_cmd_sched #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dtype (cmd_dtype),
    .cmd_op    (cmd_op),
    .cmd_src1  (cmd_src1),
    .cmd_src2  (cmd_src2),
    .mul_start (mul_start),
    .mul_dtype (mul_dtype),
    .mul_op    (mul_op),
    .mul_src1  (mul_src1),
    .mul_src2  (mul_src2),
    .mul_done  (mul_done),
    .mul_res   (mul_res),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_err   (res_err),
    .busy      (busy)
  );

  typedef struct {
    logic [3:0]  dtype;
    logic [4:0]  op;
    logic [15:0] src1;
    logic [15:0] src2;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [3:0]  dtype;
    logic [4:0]  op;
    logic [15:0] src1;
    logic [15:0] src2;
  } cmd_rec_t;

  int n_cmp = 0;
  int n_err = 0;

  // Multiplier model configuration: lat_cfg==0 means never answer
  int lat_cfg  = 6;
  bit lat_mode = 1'b0;
  int lat_log[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Multiplier model: done pulse 'lat' cycles after the start cycle, product of held operands
  initial begin
    int cnt;
    int cur;
    cnt      = 0;
    mul_done = 1'b0;
    mul_res  = '0;
    forever begin
      @(posedge clk);
      #1;
      mul_done = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          mul_done = 1'b1;
          mul_res  = 32'(mul_src1) * 32'(mul_src2);
        end
      end
      if (mul_start) begin
        if (lat_mode) begin
          cur = ($urandom_range(0, 4) == 0) ? int'($urandom_range(60, 70))
                                            : int'($urandom_range(1, 20));
        end else begin
          cur = lat_cfg;
        end
        lat_log.push_back((cur == 0) ? 1000 : cur);
        cnt = cur;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic push_cmd(input logic [3:0] d, input logic [4:0] o,
                          input logic [15:0] a, input logic [15:0] b);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_dtype = d;
    cmd_op    = o;
    cmd_src1  = a;
    cmd_src2  = b;
    while (!cmd_ready && n < 500) begin
      tick();
      n++;
    end
    if (!cmd_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL push_timeout: cmd_ready stayed 0 for %0d cycles", n);
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output int cycles);
    cycles = 0;
    while (!res_valid && cycles < budget) begin
      tick();
      cycles++;
    end
    if (!res_valid) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_valid: got no res_valid expected within %0d cycles", budget);
    end
  endtask

  vec_t        vecs[8];
  cmd_rec_t    cmd_q[$];
  cmd_rec_t    d_cmd;
  cmd_rec_t    c;
  logic        d_valid;
  logic        s_ready;
  logic        s_rvalid;
  logic        d_rready;
  logic        s_err;
  logic [31:0] s_data;
  logic [31:0] e_data;
  logic        e_err;
  int          n;
  int          idx;
  int          got;
  int          l;
  int          n_valid;
  int          n_start;
  int          n_busy;
  int          n_nready;
  int          co_lat[2];
  logic [31:0] co_data[2];
  logic        co_err[2];

  initial begin
    vecs[0] = '{4'h2, 5'h03, 16'h0003, 16'h0005, 32'h0000_000F, 1'b0};
    vecs[1] = '{4'h2, 5'h03, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b0};
    vecs[2] = '{4'h2, 5'h03, 16'h0000, 16'h1234, 32'h0000_0000, 1'b0};
    vecs[3] = '{4'h2, 5'h03, 16'h1234, 16'h0100, 32'h0012_3400, 1'b0};
    vecs[4] = '{4'h2, 5'h01, 16'h0007, 16'h0009, 32'h0000_0000, 1'b1};
    vecs[5] = '{4'h3, 5'h03, 16'h0002, 16'h0002, 32'h0000_0000, 1'b1};
    vecs[6] = '{4'hA, 5'h03, 16'h00FF, 16'h0101, 32'h0000_0000, 1'b1};
    vecs[7] = '{4'h2, 5'h13, 16'h00FF, 16'h0101, 32'h0000_0000, 1'b1};

    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_dtype = '0;
    cmd_op    = '0;
    cmd_src1  = '0;
    cmd_src2  = '0;
    res_ready = 1'b0;
    tick();
    tick();
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_mul_start", 32'(mul_start), 32'd0);
    check("rst_res_data", res_data, 32'd0);
    check("rst_res_err", 32'(res_err), 32'd0);
    check("rst_mul_src1", 32'(mul_src1), 32'd0);
    check("rst_mul_op", 32'(mul_op), 32'd0);
    rst = 1'b0;
    tick();

    // Table: one command at a time, formatter always ready
    lat_cfg   = 6;
    res_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push_cmd(vecs[i].dtype, vecs[i].op, vecs[i].src1, vecs[i].src2);
      wait_valid(100, n);
      check($sformatf("vec%0d_data", i), res_data, vecs[i].exp_data);
      check($sformatf("vec%0d_err", i), 32'(res_err), 32'(vecs[i].exp_err));
      tick();
    end
    res_ready = 1'b0;
    repeat (3) tick();

    // Single supported command: start latency, operand hold, result hold
    lat_cfg = 6;
    push_cmd(4'h2, 5'h03, 16'h0003, 16'h0005);
    check("single_start_early", 32'(mul_start), 32'd0);
    tick();
    check("single_start", 32'(mul_start), 32'd1);
    n_start = 1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (mul_start) n_start++;
      if (k == 3) begin
        check("single_hold_src1", 32'(mul_src1), 32'h3);
        check("single_hold_src2", 32'(mul_src2), 32'h5);
      end
    end
    check("single_valid_early", 32'(res_valid), 32'd0);
    tick();
    check("single_valid", 32'(res_valid), 32'd1);
    check("single_data", res_data, 32'h0000_000F);
    check("single_err", 32'(res_err), 32'd0);
    repeat (3) begin
      tick();
      if (mul_start) n_start++;
    end
    check("single_valid_held", 32'(res_valid), 32'd1);
    check("single_data_held", res_data, 32'h0000_000F);
    check("single_start_count", 32'(n_start), 32'd1);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("single_valid_drop", 32'(res_valid), 32'd0);
    repeat (2) tick();

    // Unsupported command: error result on the cycle after the pop
    push_cmd(4'h2, 5'h01, 16'h0007, 16'h0009);
    check("unsup_valid_early", 32'(res_valid), 32'd0);
    tick();
    check("unsup_valid", 32'(res_valid), 32'd1);
    check("unsup_err", 32'(res_err), 32'd1);
    check("unsup_data", res_data, 32'd0);
    check("unsup_no_start", 32'(mul_start), 32'd0);
    check("unsup_src1", 32'(mul_src1), 32'h7);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    repeat (2) tick();

    // Capacity: formatter stalled, six back-to-back pushes
    lat_cfg = 3;
    idx     = 0;
    got     = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (cyc == 12) begin
        check("cap_accepted", 32'(idx), 32'd5);
        check("cap_ready_low", 32'(cmd_ready), 32'd0);
        res_ready = 1'b1;
      end
      cmd_valid = (idx < 6);
      cmd_dtype = 4'h2;
      cmd_op    = 5'h03;
      cmd_src1  = 16'(idx + 1);
      cmd_src2  = 16'(idx + 16);
      s_ready   = cmd_ready;
      s_rvalid  = res_valid;
      s_data    = res_data;
      d_rready  = res_ready;
      d_valid   = cmd_valid;
      tick();
      if (d_valid && s_ready) idx++;
      if (s_rvalid && d_rready) begin
        if (got < 6) begin
          check($sformatf("cap_res%0d", got), s_data, 32'((got + 1) * (got + 16)));
        end
        got++;
      end
    end
    cmd_valid = 1'b0;
    res_ready = 1'b0;
    check("cap_total_accepted", 32'(idx), 32'd6);
    check("cap_total_results", 32'(got), 32'd6);

    // Timeout: multiplier never answers, then the next queued command runs normally
    lat_cfg = 0;
    push_cmd(4'h2, 5'h03, 16'h0002, 16'h0003);
    push_cmd(4'h2, 5'h03, 16'h0004, 16'h0005);
    check("to_start", 32'(mul_start), 32'd1);
    tick();
    lat_cfg = 6;
    wait_valid(200, n);
    check("to_latency", 32'(n + 1), 32'd65);
    check("to_data", res_data, 32'hFFFF_FFFF);
    check("to_err", 32'(res_err), 32'd1);
    check("to_src_held", 32'(mul_src1), 32'h2);
    res_ready = 1'b1;
    tick();
    wait_valid(100, n);
    check("to_next_data", res_data, 32'd20);
    check("to_next_err", 32'(res_err), 32'd0);
    tick();
    res_ready = 1'b0;
    repeat (2) tick();

    // Done on the last WAIT cycle wins; one cycle later is a timeout
    co_lat[0] = 64; co_data[0] = 32'h0002_0402; co_err[0] = 1'b0;
    co_lat[1] = 65; co_data[1] = 32'hFFFF_FFFF; co_err[1] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      lat_cfg   = co_lat[i];
      res_ready = 1'b1;
      push_cmd(4'h2, 5'h03, 16'h0101, 16'h0202);
      wait_valid(200, n);
      check($sformatf("edge%0d_data", co_lat[i]), res_data, co_data[i]);
      check($sformatf("edge%0d_err", co_lat[i]), 32'(res_err), 32'(co_err[i]));
      tick();
      res_ready = 1'b0;
      repeat (4) tick();
    end

    // Randomised traffic against an in-order reference queue
    lat_log.delete();
    lat_mode = 1'b1;
    for (int cyc = 0; cyc < 3500; cyc++) begin
      if (cyc < 2500 && $urandom_range(0, 9) < 7) begin
        cmd_valid = 1'b1;
        if ($urandom_range(0, 9) < 6) begin
          cmd_dtype = 4'h2;
          cmd_op    = 5'h03;
        end else begin
          cmd_dtype = 4'($urandom);
          cmd_op    = 5'($urandom);
        end
        cmd_src1 = 16'($urandom);
        cmd_src2 = 16'($urandom);
      end else begin
        cmd_valid = 1'b0;
      end
      res_ready = (cyc >= 2500) || ($urandom_range(0, 9) < 6);
      d_valid   = cmd_valid;
      d_cmd     = '{cmd_dtype, cmd_op, cmd_src1, cmd_src2};
      s_ready   = cmd_ready;
      s_rvalid  = res_valid;
      s_data    = res_data;
      s_err     = res_err;
      d_rready  = res_ready;
      tick();
      if (d_valid && s_ready) cmd_q.push_back(d_cmd);
      if (s_rvalid && d_rready) begin
        if (cmd_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL rand_extra: got result 0x%08h expected none pending", s_data);
        end else begin
          c = cmd_q.pop_front();
          if (c.dtype == 4'h2 && c.op == 5'h03) begin
            l = (lat_log.size() > 0) ? lat_log.pop_front() : 1000;
            if (l <= int'(TIMEOUT)) begin
              e_data = 32'(c.src1) * 32'(c.src2);
              e_err  = 1'b0;
            end else begin
              e_data = 32'hFFFF_FFFF;
              e_err  = 1'b1;
            end
          end else begin
            e_data = 32'd0;
            e_err  = 1'b1;
          end
          check("rand_data", s_data, e_data);
          check("rand_err", 32'(s_err), 32'(e_err));
        end
      end
    end
    lat_mode  = 1'b0;
    cmd_valid = 1'b0;
    res_ready = 1'b0;
    check("rand_drained", 32'(cmd_q.size()), 32'd0);
    check("rand_idle", 32'(busy), 32'd0);

    // Reset during WAIT with two commands queued discards everything
    lat_cfg = 20;
    push_cmd(4'h2, 5'h03, 16'h0011, 16'h0022);
    push_cmd(4'h2, 5'h03, 16'h0033, 16'h0044);
    push_cmd(4'h2, 5'h03, 16'h0055, 16'h0066);
    check("rw_busy_before", 32'(busy), 32'd1);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rw_busy", 32'(busy), 32'd0);
    check("rw_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rw_res_valid", 32'(res_valid), 32'd0);
    check("rw_mul_start", 32'(mul_start), 32'd0);
    n_valid  = 0;
    n_start  = 0;
    n_busy   = 0;
    n_nready = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (res_valid) n_valid++;
      if (mul_start) n_start++;
      if (busy) n_busy++;
      if (!cmd_ready) n_nready++;
    end
    check("rw_no_result", 32'(n_valid), 32'd0);
    check("rw_no_start", 32'(n_start), 32'd0);
    check("rw_no_busy", 32'(n_busy), 32'd0);
    check("rw_ready_kept", 32'(n_nready), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sched.md
Name: alu_cmd_sched

Overview:
- Command scheduler between the UART command parser and the shift-add multiplier.
- Buffers parsed commands in a small FIFO and decodes each one.
- Launches the multiplier with a one-cycle start pulse and holds its operands stable for the whole operation.
- Collects the product, or an error, and hands it to the result formatter over a valid/ready handshake, strictly in command order.

Parameters:
- DEPTH, 4, command FIFO entries; power of two, minimum 2.
- TIMEOUT, 64, maximum cycles spent in WAIT before the command is aborted.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  parser offers a command.
- cmd_ready  out  1  FIFO can accept; equals !full.
- cmd_dtype  in  4  data type code.
- cmd_op  in  5  operator code.
- cmd_src1  in  16  multiplier operand.
- cmd_src2  in  16  multiplicand operand.
- mul_start  out  1  one-cycle launch pulse to the multiplier (its parser_done).
- mul_dtype  out  4  registered operand to the multiplier.
- mul_op  out  5  registered operand to the multiplier.
- mul_src1  out  16  registered operand to the multiplier.
- mul_src2  out  16  registered operand to the multiplier.
- mul_done  in  1  multiplier completion pulse.
- mul_res  in  32  multiplier product, valid with mul_done.
- res_valid  out  1  result available.
- res_ready  in  1  formatter accepts the result.
- res_data  out  32  product, or error code.
- res_err  out  1  1 = unsupported command or timeout.
- busy  out  1  high when state != IDLE or the FIFO is non-empty.

Behaviour:
- Reset (rst=1 at a clock edge):
  - All outputs go to 0 except cmd_ready, which goes to 1.
  - FIFO pointers and count clear; the timer clears; state goes to IDLE.
  - A reset mid-operation discards every queued and in-flight command.
- FIFO:
  - Push when cmd_valid && cmd_ready.
  - Pop only on the IDLE-exit edge.
  - A push and a pop in the same cycle leave the count unchanged.
  - A push while full is impossible, because cmd_ready=0.
  - Pointers wrap modulo DEPTH.
- Decode: a command is supported iff dtype==4'h2 && op==5'h03.
- States: IDLE, ISSUE, WAIT, HOLD.
- IDLE:
  - FIFO non-empty: pop the head into the mul_* operand registers.
    - Supported command: go to ISSUE.
    - Unsupported command: load res_data=0 and res_err=1, then go to HOLD.
  - FIFO empty: stay in IDLE.
- ISSUE:
  - mul_start=1 for exactly this one cycle.
  - Clear the timer; go to WAIT.
- WAIT:
  - Timer increments each cycle.
  - mul_done=1: capture res_data=mul_res and res_err=0; go to HOLD.
  - Else, when timer==TIMEOUT-1: load res_data=32'hFFFF_FFFF and res_err=1; go to HOLD.
  - If mul_done and the timeout coincide, mul_done wins.
- HOLD:
  - res_valid=1; res_data and res_err stay stable.
  - On res_ready=1: go to IDLE at that edge; res_valid drops next cycle.
- Operand registers (mul_*) change only on the IDLE pop and are held through ISSUE, WAIT and HOLD.
- mul_done is ignored in every state except WAIT.
- Latency:
  - A push into an empty FIFO while IDLE pops on the next edge.
  - mul_start rises 2 cycles after the push cycle.
  - res_valid rises 1 cycle after mul_done.
- Capacity: with res_ready=0, DEPTH+1 commands are accepted (DEPTH queued plus one executing) before cmd_ready=0.
- Results leave in arrival order; there is no reordering.

Test Plan:
- Single supported command, dtype=2, op=3, src1=0x0003, src2=0x0005; bench multiplier model answers 6 cycles after start with src1*src2 -> exactly one mul_start pulse; mul_src1/mul_src2 held at 3/5 through WAIT; res_data=0x0000000F, res_err=0; res_valid held until res_ready.
- Unsupported command, op=5'h01 -> no mul_start; res_valid with res_err=1 and res_data=0 on the cycle after the pop.
- res_ready=0, push 6 supported commands back-to-back (DEPTH=4) -> 5 accepted and cmd_ready=0 from then on; release res_ready -> 5 results emitted in push order; 6th command accepted once space frees.
- Model never asserts done -> HOLD entered after 64 WAIT cycles with res_err=1 and res_data=0xFFFFFFFF; the next queued command then issues normally.
- mul_done asserted on the same cycle as timer==TIMEOUT-1 -> res_err=0 and res_data=mul_res.
- rst=1 for one cycle during WAIT with 2 commands queued -> next cycle: state IDLE, busy=0, cmd_ready=1, res_valid=0; a late mul_done causes no result.
